// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer; define MULDIV_FAST_MUL_EN for single-cycle multiplies
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            I_valid,
   input  logic [2:0]      I_op,
   input  logic [XLEN-1:0] I_src1,
   input  logic [XLEN-1:0] I_src2,
   input  logic            I_flush,
   input  logic            I_ack,
   output logic            O_ready,
   output logic            O_busy,
   output logic            O_valid,
   output logic [XLEN-1:0] O_result
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int CW = $clog2(XLEN);
   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [2:0]          r_op;
   logic                r_neg;
   logic [XLEN-1:0]     r_b;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_result;
   logic                w_s1, w_s2, w_n1, w_n2, w_div0, w_ovf, w_special, w_ge;
   logic [XLEN-1:0]     w_a1, w_a2, w_divs, w_spec_res, w_diff, w_dv, w_final;
   logic [XLEN:0]       w_sum, w_shift;
   logic [2*XLEN-1:0]   w_mstep, w_dstep, w_nacc, w_fix;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0]   w_prod;
`endif
   // operand decode: signedness, magnitudes and the no-iteration divide cases
   always_comb begin
      w_s1 = ~(I_op[0] & (I_op[1] | I_op[2]));
      w_s2 = w_s1 & (I_op != 3'd2);
      w_n1 = w_s1 & I_src1[XLEN-1];
      w_n2 = w_s2 & I_src2[XLEN-1];
      w_a1 = w_n1 ? -I_src1 : I_src1;
      w_a2 = w_n2 ? -I_src2 : I_src2;
      w_div0 = I_op[2] & (I_src2 == '0);
      w_ovf = I_op[2] & ~I_op[0] & (I_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&I_src2);
      w_divs = w_div0 ? (I_op[1] ? I_src1 : '1) : (I_op[1] ? '0 : I_src1);
`ifdef MULDIV_FAST_MUL_EN
      w_prod = $signed({{XLEN{w_n1}}, I_src1}) * $signed({{XLEN{w_n2}}, I_src2});
      w_special = w_div0 | w_ovf | ~I_op[2];
      w_spec_res = I_op[2] ? w_divs : ((I_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
`else
      w_special = w_div0 | w_ovf;
      w_spec_res = w_divs;
`endif
   end
   // one shift-add / restoring-divide step, and the sign-fixed result of the final step
   always_comb begin
      w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
      w_mstep = {w_sum, r_acc[XLEN-1:1]};
      w_shift = r_acc[2*XLEN-1:XLEN-1];
      w_ge = w_shift >= {1'b0, r_b};
      w_diff = w_shift[XLEN-1:0] - r_b;
      w_dstep = {w_ge ? w_diff : w_shift[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
      w_nacc = r_op[2] ? w_dstep : w_mstep;
      w_fix = r_neg ? -w_nacc : w_nacc;
      w_dv = r_op[1] ? w_nacc[2*XLEN-1:XLEN] : w_nacc[XLEN-1:0];
      w_final = r_op[2] ? (r_neg ? -w_dv : w_dv) : ((r_op == 3'd0) ? w_fix[XLEN-1:0] : w_fix[2*XLEN-1:XLEN]);
   end
   // sequencer: accept, iterate XLEN steps, hold result until acknowledged; flush aborts anywhere
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_op <= '0;
         r_neg <= 1'b0;
         r_b <= '0;
         r_acc <= '0;
         r_result <= '0;
      end else if (I_flush) begin
         r_state <= IDLE;
      end else if (r_state == IDLE && I_valid) begin
         r_op <= I_op;
         r_neg <= (I_op[2] & I_op[1]) ? w_n1 : w_n1 ^ w_n2;
         r_b <= I_op[2] ? w_a2 : w_a1;
         r_acc <= {{XLEN{1'b0}}, I_op[2] ? w_a1 : w_a2};
         r_cnt <= '0;
         r_state <= w_special ? DONE : CALC;
         if (w_special) r_result <= w_spec_res;
      end else if (r_state == CALC) begin
         r_acc <= w_nacc;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CW'(XLEN-1)) begin
            r_result <= w_final;
            r_state <= DONE;
         end
      end else if (r_state == DONE && I_ack) begin
         r_state <= IDLE;
      end
   end
   assign O_ready = r_state == IDLE;
   assign O_valid = r_state == DONE;
   assign O_busy = (r_state == CALC) | ((r_state == DONE) & ~I_ack);
   assign O_result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
   logic        clk, rst, I_valid, I_flush, I_ack;
   logic [2:0]  I_op;
   logic [31:0] I_src1, I_src2;
   logic        O_ready, O_busy, O_valid;
   logic [31:0] O_result;
   int errors = 0;
   int checks = 0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .I_valid(I_valid), .I_op(I_op), .I_src1(I_src1), .I_src2(I_src2),
      .I_flush(I_flush), .I_ack(I_ack), .O_ready(O_ready), .O_busy(O_busy), .O_valid(O_valid),
      .O_result(O_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // RV32M results straight from 64-bit integer arithmetic
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, q;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            q = sa / sb;
            return q[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            q = sa % sb;
            return q[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit special;
      special = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
      special = special || !op[2];
`endif
      return special ? 1 : 33;
   endfunction

   // issue one op, check O_valid rises exactly at its latency, hold hold cycles, then acknowledge
   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      int lat;
      logic [31:0] exp;
      string tag;
      exp = ref_res(op, a, b);
      lat = ref_lat(op, a, b);
      tag = $sformatf("op%0d %h,%h", op, a, b);
      @(negedge clk);
      chk({tag, " ready"}, {31'b0, O_ready}, 32'd1);
      I_valid = 1'b1; I_op = op; I_src1 = a; I_src2 = b;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) begin
            I_valid = 1'b0; I_src1 = $urandom; I_src2 = $urandom; I_op = 3'($urandom);
            chk({tag, " busy"}, {31'b0, O_busy}, 32'd1);
         end
         if (k == lat - 1 || k == lat) chk({tag, " valid"}, {31'b0, O_valid}, (k == lat) ? 32'd1 : 32'd0);
      end
      chk({tag, " result"}, O_result, exp);
      chk({tag, " busy_done"}, {31'b0, O_busy}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, " hold_valid"}, {31'b0, O_valid}, 32'd1);
         chk({tag, " hold_busy"}, {31'b0, O_busy}, 32'd1);
         chk({tag, " hold_result"}, O_result, exp);
      end
      I_ack = 1'b1;
      #1 chk({tag, " busy_ack"}, {31'b0, O_busy}, 32'd0);
      @(negedge clk);
      I_ack = 1'b0;
      chk({tag, " valid_after_ack"}, {31'b0, O_valid}, 32'd0);
      chk({tag, " ready_after_ack"}, {31'b0, O_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; I_valid = 1'b0; I_flush = 1'b0; I_ack = 1'b0;
      I_op = 3'd0; I_src1 = '0; I_src2 = '0;
      #2 rst = 1'b0;
      #1;
      chk("reset ready", {31'b0, O_ready}, 32'd1);
      chk("reset busy", {31'b0, O_busy}, 32'd0);
      chk("reset valid", {31'b0, O_valid}, 32'd0);
      chk("reset result", O_result, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      // directed vectors
      run(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run(3'd4, -32'sd20, 32'd3, 0);
      run(3'd6, -32'sd20, 32'd3, 0);
      run(3'd5, 32'd100, 32'd7, 0);
      run(3'd7, 32'd100, 32'd7, 0);
      run(3'd4, 32'd5, 32'd0, 0);
      run(3'd6, 32'd5, 32'd0, 0);
      run(3'd5, 32'd5, 32'd0, 0);
      run(3'd7, 32'd5, 32'd0, 0);
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      // result held while EX does not acknowledge
      run(3'd4, 32'd1000, -32'sd7, 5);
      // flush at cycle T+10 of a DIV
      @(negedge clk);
      I_valid = 1'b1; I_op = 3'd4; I_src1 = -32'sd20; I_src2 = 32'd3;
      @(negedge clk);
      I_valid = 1'b0;
      repeat (9) @(negedge clk);
      I_flush = 1'b1;
      @(negedge clk);
      I_flush = 1'b0;
      chk("flush ready", {31'b0, O_ready}, 32'd1);
      chk("flush busy", {31'b0, O_busy}, 32'd0);
      chk("flush valid", {31'b0, O_valid}, 32'd0);
      repeat (30) @(negedge clk);
      chk("flush valid_late", {31'b0, O_valid}, 32'd0);
      run(3'd5, 32'd9, 32'd2, 0);
      // flush together with a request in IDLE: not accepted
      @(negedge clk);
      I_valid = 1'b1; I_flush = 1'b1; I_op = 3'd4; I_src1 = 32'd5; I_src2 = 32'd0;
      @(negedge clk);
      I_valid = 1'b0; I_flush = 1'b0;
      chk("flush_req ready", {31'b0, O_ready}, 32'd1);
      chk("flush_req valid", {31'b0, O_valid}, 32'd0);
      // randomized operations
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (i % 8 == 3) ? 32'd0 : (i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom;
         run(3'($urandom_range(0, 7)), a, b, i % 3);
      end
      // async reset in the middle of an iteration
      @(negedge clk);
      I_valid = 1'b1; I_op = 3'd5; I_src1 = 32'd77; I_src2 = 32'd5;
      @(negedge clk);
      I_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst busy", {31'b0, O_busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst ready", {31'b0, O_ready}, 32'd1);
      chk("async_rst busy", {31'b0, O_busy}, 32'd0);
      chk("async_rst valid", {31'b0, O_valid}, 32'd0);
      chk("async_rst result", O_result, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run(3'd6, 32'd77, 32'd5, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
